dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data and address width in bits.
REQ-002 SHALL have parameter SIZE, default 64, the dmem depth in words.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have ports reqN  input  1, weN  input  1, aN  input  WIDTH, wdN  input  WIDTH, for N = 0 and 1: access request, write enable, byte address, write data.
REQ-006 SHALL have ports gntN  output  1, rvalidN  output  1, rdN  output  WIDTH, errN  output  1, for N = 0 and 1: grant, response valid, read data, access error.
REQ-007 SHALL have ports mem_we  output  1, mem_a  output  WIDTH, mem_wd  output  WIDTH, mem_rd  input  WIDTH, driving one dmem instance (synchronous write, combinational read).

Function
REQ-008 SHALL have a requester hold reqN, weN, aN and wdN stable from assertion until the cycle gntN is high; the request is consumed in that cycle.
REQ-009 SHALL assert at most one of gnt0/gnt1 per cycle; gntN is combinational from reqN and the priority pointer, and is 0 whenever reqN is 0 or reset is 0.
REQ-010 SHALL, in a grant cycle, drive mem_a = aN, mem_wd = wdN, mem_we = weN AND in-range; in non-grant cycles drive mem_we = 0, mem_a = 0, mem_wd = 0.
REQ-011 SHALL define in-range as aN[1:0] == 0 and aN[WIDTH-1:2] < SIZE; out-of-range accesses never write dmem.
REQ-012 SHALL assert rvalidN for exactly one cycle, the cycle after gntN, for reads and writes alike.
REQ-013 SHALL, with rvalidN, present rdN = mem_rd registered at the grant edge for an in-range read, and rdN = 0 for writes and out-of-range accesses.
REQ-014 SHALL assert errN together with rvalidN exactly when the granted access was out of range; errN is 0 otherwise.
REQ-015 SHALL hold rdN at its last value while rvalidN is 0.
REQ-016 SHALL sustain one access per cycle; back-to-back grants to the same or alternating requesters are allowed with no idle cycle.
REQ-017 SHALL track a 1-bit priority pointer, PTR0 (requester 0 preferred) or PTR1 (requester 1 preferred); with a single active request, that requester is granted regardless of pointer.
REQ-018 SHALL make a write granted in cycle t visible to a read of the same address granted in cycle t+1 or later.

Reset
REQ-019 SHALL, when reset is 0 at a rising clk, set pointer = PTR0, rvalid0 = rvalid1 = 0, rd0 = rd1 = 0, err0 = err1 = 0.
REQ-020 SHALL, if reset is asserted in the cycle after a grant, suppress that pending rvalid/err response.
REQ-021 SHALL hold gnt0 = gnt1 = 0 and mem_we = 0 throughout reset, so dmem is never written during reset.

Configuration
REQ-022 SHALL support macro DMEM_ARBITER_RR_EN.
REQ-023 SHALL, with DMEM_ARBITER_RR_EN defined, on both requests pending grant the pointer-preferred requester and then set the pointer to prefer the other requester (round-robin).
REQ-024 SHALL, without DMEM_ARBITER_RR_EN, keep the pointer fixed at PTR0 (fixed priority, requester 0 wins every conflict).

Verification
REQ-025 SHALL cover: req0 write a=8, wd=0xDEADBEEF, then req0 read a=8 -> gnt0 each cycle, rvalid0 next cycle, read returns rd0 = 0xDEADBEEF, err0 = 0.
REQ-026 SHALL cover: req0 and req1 both reading, held 4 cycles, RR_EN defined -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0 with req1 starved.
REQ-027 SHALL cover: req1 write a=256 (word 64 = SIZE) and a=6 (misaligned) -> mem_we = 0, rvalid1 = 1, err1 = 1, rd1 = 0; dmem contents unchanged.
REQ-028 SHALL cover: req0 write a=4, wd=5 and req1 read a=4 next cycle -> rd1 = 5.
REQ-029 SHALL cover: reset = 0 in the cycle after gnt1 -> rvalid1 stays 0, pointer returns to PTR0, first post-reset conflict granted to requester 0.
REQ-030 SHALL cover: no requests for 3 cycles -> gnt0 = gnt1 = 0, mem_we = 0, rvalid0 = rvalid1 = 0, rd0/rd1 hold their last values.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus bundle: requester handshakes, responses, and the dmem port.
// No storage of its own; timing is set by the arbiter that sits on the slave side.
// Requests are held by the requester until its grant; the bus carries no other stall.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             we0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] wd0;
    logic             gnt0;
    logic             rvalid0;
    logic [WIDTH-1:0] rd0;
    logic             err0;

    logic             req1;
    logic             we1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] wd1;
    logic             gnt1;
    logic             rvalid1;
    logic [WIDTH-1:0] rd1;
    logic             err1;

    logic             mem_we;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    // Arbiter side: takes requests and memory read data, drives grants, responses, memory controls.
    modport slave (
        input  req0, we0, a0, wd0, req1, we1, a1, wd1, mem_rd,
        output gnt0, rvalid0, rd0, err0, gnt1, rvalid1, rd1, err1,
        output mem_we, mem_a, mem_wd
    );

    // Environment side: requesters plus the memory model.
    modport master (
        output req0, we0, a0, wd0, req1, we1, a1, wd1, mem_rd,
        input  gnt0, rvalid0, rd0, err0, gnt1, rvalid1, rd1, err1,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one dmem (sync write, comb read); DMEM_ARBITER_RR_EN selects round-robin.
// Grant is combinational in the request cycle; response (rvalid/rd/err) arrives exactly one cycle later.
// A requester not granted simply keeps its request held; one access per cycle is sustained.
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    // Priority pointer encoding: which requester wins when both ask at once.
    localparam logic [0:0] PTR0 = 1'b0;
    localparam logic [0:0] PTR1 = 1'b1;

    localparam logic [WIDTH-1:0] SIZE_W = WIDTH'(SIZE);

    logic [0:0]       ptr_q, ptr_d;
    logic             gnt0_c, gnt1_c;
    logic             sel_we;
    logic [WIDTH-1:0] sel_a, sel_wd;
    logic             in_range;
    logic [WIDTH-1:0] rsp_rd;

    logic             rvalid0_q, rvalid1_q;
    logic             err0_q, err1_q;
    logic [WIDTH-1:0] rd0_q, rd1_q;

    // Grant decision: a lone request always wins; on conflict the pointer decides. Nothing is granted in reset.
    always_comb begin
        gnt0_c = reset & bus.req0 & (~bus.req1 | (ptr_q == PTR0));
        gnt1_c = reset & bus.req1 & (~bus.req0 | (ptr_q == PTR1));
    end

    // Steer the granted request onto the memory port; idle cycles present all-zero controls.
    always_comb begin
        sel_we = 1'b0;
        sel_a  = '0;
        sel_wd = '0;
        if (gnt1_c) begin
            sel_we = bus.we1;
            sel_a  = bus.a1;
            sel_wd = bus.wd1;
        end else if (gnt0_c) begin
            sel_we = bus.we0;
            sel_a  = bus.a0;
            sel_wd = bus.wd0;
        end
    end

    // Word-aligned and inside the array; anything else is an error and must never reach the write port.
    always_comb begin
        in_range = (sel_a[1:0] == 2'b00) && ({2'b00, sel_a[WIDTH-1:2]} < SIZE_W);
        rsp_rd   = (sel_we || !in_range) ? '0 : bus.mem_rd;
    end

    assign bus.mem_we = (gnt0_c | gnt1_c) & sel_we & in_range;
    assign bus.mem_a  = sel_a;
    assign bus.mem_wd = sel_wd;
    assign bus.gnt0   = gnt0_c;
    assign bus.gnt1   = gnt1_c;

    // Pointer update: flip after each resolved conflict when round-robin is built in, else pinned to requester 0.
    always_comb begin
`ifdef DMEM_ARBITER_RR_EN
        ptr_d = ptr_q;
        if (reset && bus.req0 && bus.req1) begin
            ptr_d = (ptr_q == PTR0) ? PTR1 : PTR0;
        end
`else
        ptr_d = PTR0;
`endif
    end

    // Capture the response of the access granted this cycle; rd holds until the next grant to that requester.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q     <= PTR0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
            err0_q    <= gnt0_c & ~in_range;
            err1_q    <= gnt1_c & ~in_range;
            if (gnt0_c) begin
                rd0_q <= rsp_rd;
            end
            if (gnt1_c) begin
                rd1_q <= rsp_rd;
            end
        end
    end

    // A response still in flight when reset arrives is dropped rather than presented.
    assign bus.rvalid0 = rvalid0_q & reset;
    assign bus.rvalid1 = rvalid1_q & reset;
    assign bus.err0    = err0_q & reset;
    assign bus.err1    = err1_q & reset;
    assign bus.rd0     = rd0_q;
    assign bus.rd1     = rd1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus randomized traffic against a reference model.
// The memory model is synchronous-write / combinational-read and lives here in the bench.
// Requests are held until the model predicts their grant, as a real requester would.
module tb_dmem_arbiter;
    localparam int SIZE = 64;
`ifdef DMEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  eg;           // expected {gnt1, gnt0}
        logic        ev0, ee0;
        logic [31:0] erd0;
        logic        ev1, ee1;
        logic [31:0] erd1;
    } vec_t;

    logic clk;
    logic reset;
    logic clr;
    logic [31:0] dmem [SIZE];

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    int          conf;
    bit          pv [2];
    bit          pe [2];
    logic [31:0] mrd [2];
    logic [31:0] mmem [SIZE];

    dmem_arbiter_if #(.WIDTH(32)) bus ();

    dmem_arbiter #(.WIDTH(32), .SIZE(SIZE)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, synchronous write, out-of-range reads return a nonzero pattern.
    assign bus.mem_rd = (bus.mem_a[31:2] < 30'(SIZE)) ? dmem[bus.mem_a[7:2]] : 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < SIZE; k++) dmem[k] <= '0;
        end else if (bus.mem_we && (bus.mem_a[31:2] < 30'(SIZE))) begin
            dmem[bus.mem_a[7:2]] <= bus.mem_wd;
        end
    end

    function automatic void chk(string nm, int cyc, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @step %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [31:0] a1, logic [31:0] d1, logic [1:0] eg,
                                logic ev0, logic ee0, logic [31:0] erd0,
                                logic ev1, logic ee1, logic [31:0] erd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.eg = eg;
        v.ev0 = ev0; v.ee0 = ee0; v.erd0 = erd0;
        v.ev1 = ev1; v.ee1 = ee1; v.erd1 = erd1;
        return v;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < SIZE);
    endfunction

    // One clock cycle: drive, check at negedge against model (and table if given), then advance the model.
    task automatic step(input vec_t v, input bit has_exp, input int cyc, output int w);
        logic        we;
        logic [31:0] a, d;
        bit          inr;
        reset   = v.rst;
        bus.req0 = v.r0; bus.we0 = v.w0; bus.a0 = v.a0; bus.wd0 = v.d0;
        bus.req1 = v.r1; bus.we1 = v.w1; bus.a1 = v.a1; bus.wd1 = v.d1;
        @(negedge clk);
        if (!v.rst)            w = -1;
        else if (v.r0 && v.r1) w = RR ? (conf % 2) : 0;
        else if (v.r0)         w = 0;
        else if (v.r1)         w = 1;
        else                   w = -1;
        we  = (w == 1) ? v.w1 : v.w0;
        a   = (w == 1) ? v.a1 : v.a0;
        d   = (w == 1) ? v.d1 : v.d0;
        inr = in_rng(a);
        chk("gnt0", cyc, 32'(bus.gnt0), 32'(w == 0));
        chk("gnt1", cyc, 32'(bus.gnt1), 32'(w == 1));
        chk("mem_we", cyc, 32'(bus.mem_we), 32'((w >= 0) && we && inr));
        chk("mem_a", cyc, bus.mem_a, (w >= 0) ? a : 32'h0);
        chk("mem_wd", cyc, bus.mem_wd, (w >= 0) ? d : 32'h0);
        chk("rvalid0", cyc, 32'(bus.rvalid0), 32'(pv[0] && v.rst));
        chk("rvalid1", cyc, 32'(bus.rvalid1), 32'(pv[1] && v.rst));
        chk("err0", cyc, 32'(bus.err0), 32'(pe[0] && v.rst));
        chk("err1", cyc, 32'(bus.err1), 32'(pe[1] && v.rst));
        chk("rd0", cyc, bus.rd0, mrd[0]);
        chk("rd1", cyc, bus.rd1, mrd[1]);
        if (has_exp) begin
            chk("tbl_gnt", cyc, {30'h0, bus.gnt1, bus.gnt0}, {30'h0, v.eg});
            chk("tbl_rv0", cyc, 32'(bus.rvalid0), 32'(v.ev0));
            chk("tbl_err0", cyc, 32'(bus.err0), 32'(v.ee0));
            chk("tbl_rd0", cyc, bus.rd0, v.erd0);
            chk("tbl_rv1", cyc, 32'(bus.rvalid1), 32'(v.ev1));
            chk("tbl_err1", cyc, 32'(bus.err1), 32'(v.ee1));
            chk("tbl_rd1", cyc, bus.rd1, v.erd1);
        end
        @(posedge clk);
        if (!v.rst) begin
            conf = 0;
            for (int k = 0; k < 2; k++) begin pv[k] = 0; pe[k] = 0; mrd[k] = '0; end
        end else begin
            if (v.r0 && v.r1) conf++;
            for (int k = 0; k < 2; k++) begin
                pv[k] = (w == k);
                pe[k] = (w == k) && !inr;
            end
            if (w >= 0) begin
                mrd[w] = (!we && inr) ? mmem[a / 4] : 32'h0;
                if (we && inr) mmem[a / 4] = d;
            end
        end
        #1;
    endtask

    vec_t tbl [23];

    initial begin
        int          w;
        vec_t        rv;
        bit          pend [2];
        logic        pw [2];
        logic [31:0] pa [2], pd [2];

        clr = 1'b1;
        reset = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.a0 = '0; bus.wd0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.a1 = '0; bus.wd1 = '0;
        conf = 0;
        for (int k = 0; k < 2; k++) begin pv[k] = 0; pe[k] = 0; mrd[k] = '0; pend[k] = 0; end
        for (int k = 0; k < SIZE; k++) mmem[k] = '0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;

        //             rst r0 w0 a0      d0            r1 w1 a1      d1       eg     v0 e0 rd0           v1 e1 rd1
        tbl[0]  = mk(0, 1, 1, 32'd0,   32'hFFFF_FFFF, 0, 0, 32'd0,   32'd0,    2'b00, 0, 0, 32'h0,        0, 0, 32'h0);
        tbl[1]  = mk(1, 1, 1, 32'd8,   32'hDEAD_BEEF, 0, 0, 32'd0,   32'd0,    2'b01, 0, 0, 32'h0,        0, 0, 32'h0);
        tbl[2]  = mk(1, 1, 0, 32'd8,   32'd0,         0, 0, 32'd0,   32'd0,    2'b01, 1, 0, 32'h0,        0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b00, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b00, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = mk(1, 0, 0, 32'd0,   32'd0,         1, 1, 32'd256, 32'h1234, 2'b10, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[8]  = mk(1, 0, 0, 32'd0,   32'd0,         1, 1, 32'd6,   32'h5678, 2'b10, 0, 0, 32'hDEAD_BEEF, 1, 1, 32'h0);
        tbl[9]  = mk(1, 1, 0, 32'd4,   32'd0,         0, 0, 32'd0,   32'd0,    2'b01, 0, 0, 32'hDEAD_BEEF, 1, 1, 32'h0);
        tbl[10] = mk(1, 1, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b01, 1, 0, 32'h0,        0, 0, 32'h0);
        tbl[11] = mk(1, 1, 1, 32'd4,   32'd5,         0, 0, 32'd0,   32'd0,    2'b01, 1, 0, 32'h0,        0, 0, 32'h0);
        tbl[12] = mk(1, 0, 0, 32'd0,   32'd0,         1, 0, 32'd4,   32'd0,    2'b10, 1, 0, 32'h0,        0, 0, 32'h0);
        tbl[13] = mk(1, 0, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b00, 0, 0, 32'h0,        1, 0, 32'd5);
`ifdef DMEM_ARBITER_RR_EN
        tbl[14] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 0, 0, 32'h0,        0, 0, 32'd5);
        tbl[15] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b10, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'd5);
        tbl[16] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 0, 0, 32'hDEAD_BEEF, 1, 0, 32'd5);
        tbl[17] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b10, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'd5);
        tbl[18] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 0, 0, 32'hDEAD_BEEF, 1, 0, 32'd5);
`else
        tbl[14] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 0, 0, 32'h0,        0, 0, 32'd5);
        tbl[15] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'd5);
        tbl[16] = tbl[15];
        tbl[17] = tbl[15];
        tbl[18] = tbl[15];
`endif
        tbl[19] = mk(1, 0, 0, 32'd0,   32'd0,         1, 0, 32'd4,   32'd0,    2'b10, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'd5);
        tbl[20] = mk(0, 0, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b00, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'd5);
        tbl[21] = mk(1, 1, 0, 32'd8,   32'd0,         1, 0, 32'd4,   32'd0,    2'b01, 0, 0, 32'h0,        0, 0, 32'h0);
        tbl[22] = mk(1, 0, 0, 32'd0,   32'd0,         0, 0, 32'd0,   32'd0,    2'b00, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);

        for (int i = 0; i < 23; i++) step(tbl[i], 1'b1, i, w);

        // Randomized traffic: each requester holds its request until the model predicts its grant.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && ($urandom_range(0, 99) < 60)) begin
                    pend[k] = 1'b1;
                    pw[k]   = 1'($urandom_range(0, 1));
                    pd[k]   = $urandom;
                    case ($urandom_range(0, 9))
                        0:       pa[k] = 32'(256 + 4 * $urandom_range(0, 63));
                        1:       pa[k] = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                        default: pa[k] = 32'(4 * $urandom_range(0, 15));
                    endcase
                end
            end
            rv = mk(($urandom_range(0, 49) != 0), pend[0], pw[0], pa[0], pd[0],
                    pend[1], pw[1], pa[1], pd[1], 2'b00, 0, 0, 32'h0, 0, 0, 32'h0);
            step(rv, 1'b0, 100 + c, w);
            if (w >= 0) pend[w] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
